seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder.sv | 159 +++++++++++++++
 tb/tb_seq_chunk_adder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder/subtractor. Each clock it processes CHUNK bits of the two
//   WIDTH-bit operands through a ripple of full-adder cells. The carry between
//   chunks is held in a carry register. An operation takes N = WIDTH/CHUNK
//   clocks from the accepting edge to the done pulse.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   CHUNK  bits per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request
//   a, b   in   operands, sampled on the accepting edge
//   cin    in   carry-in (add) / borrow-in (sub), sampled with start
//   sub    in   0: a+b+cin, 1: a-b-cin, sampled with start
//   busy   out  operation in progress
//   done   out  one-cycle pulse when sum/cout/ovf update
//   sum    out  result, held until the next completion
//   cout   out  add: carry out; sub: 1 = no borrow
//   ovf    out  two's-complement overflow of the result
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; result registers hold the last result
// S_RUN  | processing one chunk per clock, count selects the chunk
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH (>= 1)");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    // Single-bit A+B+C cell, returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    logic [CHUNK-1:0] chunk_sum;
    logic [CHUNK:0]   chunk_c;

    always_comb begin
        chunk_sum  = '0;
        chunk_c    = '0;
        chunk_c[0] = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            {chunk_c[i+1], chunk_sum[i]} = full_add(a_q[i], b_q[i], chunk_c[i]);
        end
    end

    logic [WIDTH-1:0] res_d;
    logic             last_chunk;
    logic             accept;

    // New chunk bits enter at the top so the first chunk ends up at bit 0.
    assign res_d      = (res_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
    assign last_chunk = (cnt_q == CW'(N - 1));

    // The completion edge also accepts a new request, so a held start gives
    // one operation every N clocks with busy staying high in between.
    assign accept = start & ((state_q == S_IDLE) | last_chunk);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= chunk_c[CHUNK];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        sum_q   <= res_d;
                        cout_q  <= chunk_c[CHUNK];
                        // chunk_c[CHUNK-1] is the carry into the MSB cell
                        ovf_q   <= chunk_c[CHUNK-1] ^ chunk_c[CHUNK];
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (accept) begin
                a_q     <= a;
                b_q     <= sub ? ~b : b;
                // subtraction is a + ~b + 1 - borrow_in
                carry_q <= cin ^ sub;
                cnt_q   <= '0;
                res_q   <= '0;
                state_q <= S_RUN;
            end
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=1, CHUNK=1
    logic start0, a0, b0, cin0, sub0;
    logic busy0, done0, sum0, cout0, ovf0;
    // DUT 1: WIDTH=8, CHUNK=1
    logic start1, cin1, sub1;
    logic [7:0] a1, b1;
    logic busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    // DUT 2: WIDTH=8, CHUNK=4
    logic start2, cin2, sub2;
    logic [7:0] a2, b2;
    logic busy2, done2, cout2, ovf2;
    logic [7:0] sum2;

    seq_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );
    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb,
                         output logic [7:0] s, output logic co, output logic ov);
        longint mask, av, bv, bo, full, half, sa, sbv, r;
        mask = (longint'(1) << w) - 1;
        av   = longint'(a) & mask;
        bo   = longint'(b) & mask;
        bv   = sb ? (~bo & mask) : bo;
        full = av + bv + longint'(ci ^ sb);
        s    = 8'(full & mask);
        co   = ((full >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - (longint'(1) << w) : av;
        sbv  = (bo >= half) ? bo - (longint'(1) << w) : bo;
        r    = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
        ov   = (r >= half) || (r < -half);
    endtask

    task automatic drive(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb, input logic st);
        case (d)
            0: begin a0 = a[0]; b0 = b[0]; cin0 = ci; sub0 = sb; start0 = st; end
            1: begin a1 = a;    b1 = b;    cin1 = ci; sub1 = sb; start1 = st; end
            default: begin a2 = a; b2 = b; cin2 = ci; sub2 = sb; start2 = st; end
        endcase
    endtask

    function automatic logic [31:0] get_done(input int d);
        return (d == 0) ? 32'(done0) : (d == 1) ? 32'(done1) : 32'(done2);
    endfunction
    function automatic logic [31:0] get_busy(input int d);
        return (d == 0) ? 32'(busy0) : (d == 1) ? 32'(busy1) : 32'(busy2);
    endfunction
    function automatic logic [31:0] get_sum(input int d);
        return (d == 0) ? 32'(sum0) : (d == 1) ? 32'(sum1) : 32'(sum2);
    endfunction
    function automatic logic [31:0] get_cout(input int d);
        return (d == 0) ? 32'(cout0) : (d == 1) ? 32'(cout1) : 32'(cout2);
    endfunction
    function automatic logic [31:0] get_ovf(input int d);
        return (d == 0) ? 32'(ovf0) : (d == 1) ? 32'(ovf1) : 32'(ovf2);
    endfunction
    function automatic int n_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 8 : 2;
    endfunction
    function automatic int w_of(input int d);
        return (d == 0) ? 1 : 8;
    endfunction

    // One operation: start for one edge, scramble inputs afterwards, wait for done.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb, output int lat,
                          output logic [31:0] s, output logic [31:0] co, output logic [31:0] ov);
        logic [31:0] s_prev;
        logic [31:0] busy_at_done;
        int unstable;
        drive(d, a, b, ci, sb, 1'b1);
        @(posedge clk); #1;
        drive(d, ~a, ~b, ~ci, ~sb, 1'b0);
        chk("busy_after_start", get_busy(d), 1);
        s_prev = get_sum(d);
        unstable = 0;
        busy_at_done = 1;
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (get_done(d) != 0) begin
                lat = c;
                busy_at_done = get_busy(d);
            end else if (get_sum(d) !== s_prev) begin
                unstable = 1;
            end
        end
        s  = get_sum(d);
        co = get_cout(d);
        ov = get_ovf(d);
        chk("sum_stable_while_busy", unstable, 0);
        chk("busy_low_at_done", busy_at_done, 0);
        @(posedge clk); #1;
        chk("done_single_pulse", get_done(d), 0);
    endtask

    task automatic op_vs_model(input int d, input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic ci, input logic sb);
        int lat;
        logic [31:0] s, co, ov;
        logic [7:0] es;
        logic ec, eo;
        model(w_of(d), a, b, ci, sb, es, ec, eo);
        run_op(d, a, b, ci, sb, lat, s, co, ov);
        chk({tag, "_latency"}, lat, n_of(d));
        chk({tag, "_sum"}, s, 32'(es));
        chk({tag, "_cout"}, co, 32'(ec));
        chk({tag, "_ovf"}, ov, 32'(eo));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] s, co, ov;

        tbl[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, s: 8'h96, co: 1'b0, ov: 1'b1};
        tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, s: 8'hF0, co: 1'b0, ov: 1'b0};
        tbl[3] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h7F, co: 1'b1, ov: 1'b1};
        tbl[4] = '{a: 8'h05, b: 8'h05, cin: 1'b1, sub: 1'b1, s: 8'hFF, co: 1'b0, ov: 1'b0};

        for (int d = 0; d < 3; d++) drive(d, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy1), 0);
        chk("reset_done", 32'(done1), 0);
        chk("reset_sum", 32'(sum1), 0);
        chk("reset_cout", 32'(cout1), 0);
        chk("reset_ovf", 32'(ovf1), 0);
        chk("reset_busy_w1", 32'(busy0), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WIDTH=1 registered full adder, all eight input combinations
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic es, ec;
            v  = 3'(i);
            es = v[2] ^ v[1] ^ v[0];
            ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            run_op(0, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, lat, s, co, ov);
            chk("w1_latency", lat, 1);
            chk("w1_sum", s, 32'(es));
            chk("w1_cout", co, 32'(ec));
            chk("w1_ovf", ov, 32'(v[0] ^ ec));
        end

        // WIDTH=8, CHUNK=1 directed table
        for (int i = 0; i < 5; i++) begin
            run_op(1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat, s, co, ov);
            chk("tbl_latency", lat, 8);
            chk("tbl_sum", s, 32'(tbl[i].s));
            chk("tbl_cout", co, 32'(tbl[i].co));
            chk("tbl_ovf", ov, 32'(tbl[i].ov));
        end

        // WIDTH=8, CHUNK=4: 0x7F + 0x01
        run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, lat, s, co, ov);
        chk("c4_latency", lat, 2);
        chk("c4_sum", s, 32'h80);
        chk("c4_cout", co, 0);
        chk("c4_ovf", ov, 1);

        // CHUNK=4 with start held: one result every 2 clocks
        begin
            logic [7:0] oa[4], ob[4];
            logic oc[4], os[4];
            logic [7:0] es;
            logic ec, eo;
            for (int i = 0; i < 4; i++) begin
                oa[i] = 8'($urandom); ob[i] = 8'($urandom);
                oc[i] = 1'($urandom); os[i] = 1'($urandom);
            end
            drive(2, oa[0], ob[0], oc[0], os[0], 1'b1);
            @(posedge clk); #1;
            for (int i = 1; i <= 4; i++) begin
                if (i < 4) drive(2, oa[i], ob[i], oc[i], os[i], 1'b1);
                else       drive(2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
                @(posedge clk); #1;
                chk("b2b_mid_done", get_done(2), 0);
                chk("b2b_mid_busy", get_busy(2), 1);
                @(posedge clk); #1;
                model(8, oa[i-1], ob[i-1], oc[i-1], os[i-1], es, ec, eo);
                chk("b2b_done", get_done(2), 1);
                chk("b2b_sum", get_sum(2), 32'(es));
                chk("b2b_cout", get_cout(2), 32'(ec));
                chk("b2b_ovf", get_ovf(2), 32'(eo));
            end
            chk("b2b_busy_end", get_busy(2), 0);
            @(posedge clk); #1;
            chk("b2b_done_end", get_done(2), 0);
        end

        // start pulsed during a busy run is ignored
        begin
            int first;
            int ndone;
            logic [31:0] s_first;
            first = -1; ndone = 0; s_first = 0;
            drive(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
            drive(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            for (int c = 1; c <= 16; c++) begin
                if (c == 3) drive(1, 8'hC3, 8'h11, 1'b1, 1'b1, 1'b1);
                if (c == 4) drive(1, 8'hC3, 8'h11, 1'b1, 1'b1, 1'b0);
                @(posedge clk); #1;
                if (done1) begin
                    ndone++;
                    if (first < 0) begin
                        first = c;
                        s_first = 32'(sum1);
                    end
                end
            end
            chk("ign_latency", first, 8);
            chk("ign_done_count", ndone, 1);
            chk("ign_sum", s_first, 32'h96);
        end

        // reset in the middle of a run
        begin
            int ndone;
            ndone = 0;
            drive(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
            @(posedge clk); #1;
            drive(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            repeat (4) @(posedge clk);
            #3;
            chk("pre_rst_busy", 32'(busy1), 1);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_busy", 32'(busy1), 0);
            chk("mid_rst_done", 32'(done1), 0);
            chk("mid_rst_sum", 32'(sum1), 0);
            chk("mid_rst_cout", 32'(cout1), 0);
            chk("mid_rst_ovf", 32'(ovf1), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done1) ndone++;
            end
            chk("post_rst_no_done", ndone, 0);
        end

        // randomized operations against the arithmetic model
        for (int i = 0; i < 16; i++)
            op_vs_model(1, "rnd_c1", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 16; i++)
            op_vs_model(2, "rnd_c4", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++)
            op_vs_model(0, "rnd_w1", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
